// File: rtl/mrv1_imem_resp.sv
// Instruction-memory responder: fixed-latency, in-order fetch pipeline over a
// word-addressed RAM, with a program-load write port and a sticky fetch-error capture.
module mrv1_imem_resp #(
  parameter int DEPTH_P = 1024,
  parameter int LATENCY_P = 2,
  localparam int addr_width_lp = $clog2(DEPTH_P)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_vld_i,
  output logic        imem_req_rdy_o,
  input  logic [31:0] imem_req_addr_i,
  output logic        imem_resp_vld_o,
  output logic [31:0] imem_resp_data_o,
  input  logic        load_vld_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_P));
  endfunction

  function automatic logic [addr_width_lp-1:0] word_idx(input logic [31:0] a);
    return a[addr_width_lp+1:2];
  endfunction

  logic [31:0]          mem [DEPTH_P];
  logic                 req_acc;
  logic                 req_bad;
  logic [LATENCY_P-1:0] vld_p;
  logic                 err_p  [LATENCY_P];
  logic [31:0]          data_p [LATENCY_P];
  logic [31:0]          addr_p [LATENCY_P];
  logic                 err_q;
  logic [31:0]          err_addr_q;
  logic                 err_now;

  // A load always wins the cycle, which keeps the RAM single-ported.
  assign imem_req_rdy_o = !load_vld_i;
  assign req_acc        = imem_req_vld_i && imem_req_rdy_o;
  assign req_bad        = addr_bad(imem_req_addr_i);

  always_ff @(posedge clk_i) begin
    if (load_vld_i && !addr_bad(load_addr_i)) begin
      mem[word_idx(load_addr_i)] <= load_data_i;
    end
  end

  // Stage p0 is captured at the acceptance edge; stage p[LATENCY_P-1] drives the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p <= (vld_p << 1) | LATENCY_P'(req_acc);
    end
  end

  always_ff @(posedge clk_i) begin
    data_p[0] <= req_bad ? 32'h0000_0000 : mem[word_idx(imem_req_addr_i)];
    err_p[0]  <= req_bad;
    addr_p[0] <= imem_req_addr_i;
    for (int k = 1; k < LATENCY_P; k++) begin
      data_p[k] <= data_p[k-1];
      err_p[k]  <= err_p[k-1];
      addr_p[k] <= addr_p[k-1];
    end
  end

  // Output stage: data is forced to zero whenever no response is presented.
  assign imem_resp_vld_o  = vld_p[LATENCY_P-1];
  assign imem_resp_data_o = vld_p[LATENCY_P-1] ? data_p[LATENCY_P-1] : 32'h0000_0000;

  // The error flag rises together with the first erroneous response, then sticks.
  assign err_now = vld_p[LATENCY_P-1] && err_p[LATENCY_P-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else if (err_now && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= addr_p[LATENCY_P-1];
    end
  end

  assign err_o      = err_q || err_now;
  assign err_addr_o = err_q ? err_addr_q : (err_now ? addr_p[LATENCY_P-1] : 32'h0000_0000);

endmodule

// File: doc/mrv1_imem_resp.md
MRV1_IMEM_RESP -- requirements
Module: mrv1_imem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_P, default 1024: instruction memory depth in 32-bit words, a power of two.
REQ-002 The block SHALL have parameter LATENCY_P, default 2: cycles from request acceptance to response, legal range 1..4.
REQ-003 The block SHALL have derived parameter addr_width_lp = $clog2(DEPTH_P): word-index width.
REQ-004 The block SHALL have clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have imem_req_vld_i, input, 1 bit: fetch request valid from the IFETCH initiator.
REQ-007 The block SHALL have imem_req_rdy_o, output, 1 bit: responder can accept a request this cycle.
REQ-008 The block SHALL have imem_req_addr_i, input, 32 bits: byte address of the instruction.
REQ-009 The block SHALL have imem_resp_vld_o, output, 1 bit: response data valid, one-cycle pulse per request.
REQ-010 The block SHALL have imem_resp_data_o, output, 32 bits: instruction word.
REQ-011 The block SHALL have load_vld_i, input, 1 bit: program-load write strobe.
REQ-012 The block SHALL have load_addr_i, input, 32 bits: program-load byte address.
REQ-013 The block SHALL have load_data_i, input, 32 bits: program-load word.
REQ-014 The block SHALL have err_o, output, 1 bit: sticky fetch-error flag.
REQ-015 The block SHALL have err_addr_o, output, 32 bits: byte address of the first erroneous fetch.

Function
REQ-016 A request SHALL be accepted on a rising edge where imem_req_vld_i && imem_req_rdy_o.
REQ-017 imem_req_rdy_o SHALL equal !load_vld_i combinationally, with no other stall source.
REQ-018 Sustained throughput SHALL be one accepted request per cycle with no bubbles.
REQ-019 A request accepted at edge N SHALL produce imem_resp_vld_o=1 in exactly the cycle following edge N+LATENCY_P-1, i.e. LATENCY_P cycles after acceptance.
REQ-020 Responses SHALL be returned strictly in acceptance order.
REQ-021 The responder SHALL implement a LATENCY_P-deep shift pipeline of {valid, data, err}, with no response backpressure (the initiator has no resp ready).
REQ-022 The read data SHALL be sampled from memory at the acceptance edge, word index imem_req_addr_i[addr_width_lp+1:2].
REQ-023 A request SHALL be erroneous if imem_req_addr_i[1:0]!=0 or imem_req_addr_i[31:2] >= DEPTH_P.
REQ-024 An erroneous request SHALL still respond with the same latency, with data 32'h0000_0000.
REQ-025 On the first erroneous response, err_o SHALL set to 1 and err_addr_o SHALL capture the request address; both SHALL hold until reset, and later errors SHALL NOT overwrite err_addr_o.
REQ-026 A load on an edge with load_vld_i=1 SHALL write mem[load_addr_i[addr_width_lp+1:2]] <= load_data_i.
REQ-027 A load with out-of-range or misaligned load_addr_i SHALL be ignored silently.
REQ-028 Load and request acceptance SHALL be mutually exclusive per cycle (REQ-017), so there is no same-cycle read/write conflict.
REQ-029 A request accepted after a load edge SHALL return the newly loaded word.
REQ-030 Requests already in flight at a load edge SHALL return the old data.
REQ-031 imem_resp_data_o SHALL be don't-care when imem_resp_vld_o=0, and the implementation SHALL drive 0 in that case.
REQ-032 With imem_req_vld_i=0 and no requests in flight, imem_resp_vld_o SHALL remain 0.

Reset
REQ-033 During and after rst_i assertion: imem_resp_vld_o=0, imem_resp_data_o=0, err_o=0, err_addr_o=0, and all pipeline valid bits cleared.
REQ-034 imem_req_rdy_o SHALL follow REQ-017 even during reset.
REQ-035 Assertion of rst_i mid-operation SHALL discard in-flight responses; none SHALL appear after deassertion.
REQ-036 Memory contents SHALL NOT be affected by reset.
REQ-037 The first acceptance SHALL be possible on the first rising edge after rst_i deasserts.

Verification
REQ-038 Scenario: LATENCY_P=2; load mem[0..3]={A0,A1,A2,A3}; back-to-back requests at 0x0,0x4,0x8,0xC -> resp_vld high 4 consecutive cycles, starting 2 cycles after the first accept, data A0..A3 in order.
REQ-039 Scenario: request 0x6, then 0x4000 (DEPTH_P=1024) -> both responses carry data 0; err_o=1; err_addr_o=0x6 and stays 0x6.
REQ-040 Scenario: request at 0x10 while load_vld_i=1 to 0x10 with data 0xDEADBEEF -> rdy=0 that cycle; request accepted next cycle returns 0xDEADBEEF; a 0x10 request accepted before the load returns the old value.
REQ-041 Scenario: 3 requests in flight, rst_i pulsed for 1 cycle -> no resp_vld after reset, err_o=0, memory still readable with pre-reset contents.
REQ-042 Scenario: LATENCY_P=1 and LATENCY_P=4 sweeps with random vld gaps -> every response exactly LATENCY_P cycles after its accept, count of responses equal to count of accepts.
